// File: rtl/bram_read_streamer_if.sv
// Bundles the streamer's control, buffer read port and output stream.
// BRAM_STREAM_PERF_EN adds the stall_cnt counter output.
interface bram_read_streamer_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 11
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [LEN_WIDTH-1:0]  length;
   logic                  busy;
   logic                  done;
   logic                  bram_rd_en;
   logic [ADDR_WIDTH-1:0] bram_rd_addr;
   logic [DATA_WIDTH-1:0] bram_rd_data;
   // Stream: a word moves on a cycle where m_valid and m_ready are both high;
   // m_data/m_last stay put while m_valid=1 and m_ready=0.
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic [1:0]            dbg_state;
`ifdef BRAM_STREAM_PERF_EN
   logic [15:0]           stall_cnt;
`endif

   modport master (
      input  start, base_addr, length, bram_rd_data, m_ready,
      output busy, done, bram_rd_en, bram_rd_addr, m_valid, m_data, m_last, dbg_state
`ifdef BRAM_STREAM_PERF_EN
      , output stall_cnt
`endif
   );

   modport slave (
      output start, base_addr, length, bram_rd_data, m_ready,
      input  busy, done, bram_rd_en, bram_rd_addr, m_valid, m_data, m_last, dbg_state
`ifdef BRAM_STREAM_PERF_EN
      , input stall_cnt
`endif
   );
endinterface

// File: rtl/bram_read_streamer.sv
// Burst reader: issues buffer reads and streams the words out through a 2-entry skid FIFO.
// Optional BRAM_STREAM_PERF_EN adds a saturating backpressure stall counter.
module bram_read_streamer #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   bram_read_streamer_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
   logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic                  done_q, done_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] fifo_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            count_q, count_d;

   logic       rd_en, push, pop, accept;
   logic [2:0] occupancy;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issue_cnt_d = issue_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      done_d      = 1'b0;
      push        = inflight_q;
      pop         = (count_q != 2'd0) && bus.m_ready;
      accept      = (state_q == IDLE) && bus.start;
      // Words already held or on their way, minus the one leaving now.
      occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      rd_en       = (state_q == RUN) && (issue_cnt_q != '0) && (occupancy < 3'd2);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.length != '0) begin
                  state_d     = RUN;
                  addr_d      = bus.base_addr;
                  issue_cnt_d = bus.length;
                  beat_cnt_d  = bus.length;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (rd_en) begin
               addr_d      = addr_q + ADDR_WIDTH'(1);
               issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
               if (issue_cnt_q == LEN_WIDTH'(1)) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (pop && beat_cnt_q == LEN_WIDTH'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         done_q      <= 1'b0;
         inflight_q  <= 1'b0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         issue_cnt_q <= issue_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         done_q      <= done_d;
         inflight_q  <= rd_en;
         count_q     <= count_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.bram_rd_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   assign bus.busy         = (state_q != IDLE);
   assign bus.done         = done_q;
   assign bus.bram_rd_en   = rd_en;
   assign bus.bram_rd_addr = addr_q;
   assign bus.m_valid      = (count_q != 2'd0);
   assign bus.m_data       = fifo_q[rd_ptr_q];
   assign bus.m_last       = (count_q != 2'd0) && (beat_cnt_q == LEN_WIDTH'(1));
   assign bus.dbg_state    = state_q;

   // The issue rule keeps held + in-flight words at two or fewer.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && count_q == 2'd2));

`ifdef BRAM_STREAM_PERF_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (accept) begin
         stall_cnt_q <= '0;
      end else if ((state_q != IDLE) && (count_q != 2'd0) && !bus.m_ready &&
                   (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_bram_read_streamer.sv
// Self-checking bench for bram_read_streamer: directed scenarios plus random bursts,
// all outputs compared every cycle against a queue-based model of the burst contents.
module tb_bram_read_streamer;
   localparam int AW = 10;
   localparam int DW = 16;
   localparam int LW = 11;

   logic clk = 1'b0;
   logic rst = 1'b0;

   bram_read_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus_if ();

   bram_read_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Buffer model with one-cycle synchronous read.
   logic [DW-1:0] mem [1<<AW];
   always @(posedge clk) if (bus_if.bram_rd_en) bus_if.bram_rd_data <= mem[bus_if.bram_rd_addr];

   int checks   = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   // Model: expected stream words, outstanding reads, busy and done timing.
   logic [DW-1:0] exp_q[$];
   bit            m_busy    = 0;
   bit            done_pend = 0;
   int            rd_rem    = 0;
   logic [AW-1:0] rd_next   = '0;
   int            outstanding = 0;
   int            beat_total  = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_busy = 0; done_pend = 0; rd_rem = 0; outstanding = 0;
      end else begin
         bit cur_busy;
         cur_busy = m_busy;
         check("done", bus_if.done, done_pend);
         check("busy", bus_if.busy, cur_busy);
         done_pend = 0;
         if (bus_if.bram_rd_en) begin
            check("rd_expected", rd_rem > 0, 1);
            check("rd_addr", bus_if.bram_rd_addr, rd_next);
            rd_next = rd_next + AW'(1);
            if (rd_rem > 0) rd_rem--;
            outstanding++;
         end
         if (bus_if.m_valid) begin
            check("valid_has_word", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               check("m_data", bus_if.m_data, exp_q[0]);
               check("m_last", bus_if.m_last, exp_q.size() == 1);
               if (bus_if.m_ready) begin
                  void'(exp_q.pop_front());
                  beat_total++;
                  outstanding--;
                  if (exp_q.size() == 0) begin
                     done_pend = 1;
                     m_busy    = 0;
                  end
               end
            end
         end
         check("occupancy_le_2", outstanding <= 2, 1);
         if (bus_if.start && !cur_busy) begin
            if (bus_if.length == '0) begin
               done_pend = 1;
            end else begin
               for (int i = 0; i < int'(bus_if.length); i++)
                  exp_q.push_back(mem[AW'(int'(bus_if.base_addr) + i)]);
               rd_rem  = int'(bus_if.length);
               rd_next = bus_if.base_addr;
               m_busy  = 1;
            end
         end
      end
   end

   task automatic start_burst(input logic [AW-1:0] b, input logic [LW-1:0] l);
      @(posedge clk); #1;
      bus_if.start = 1'b1; bus_if.base_addr = b; bus_if.length = l;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
   endtask

   // Runs until done is seen; ready_pct<0 leaves m_ready alone, junk starts are pulsed while busy.
   task automatic wait_done(input int bound, input int ready_pct, input bit junk);
      bit got;
      got = 0;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (bus_if.done) begin
            bus_if.start = 1'b0;
            got = 1;
            break;
         end
         if (ready_pct >= 0) bus_if.m_ready = ($urandom_range(0, 99) < ready_pct);
         bus_if.start = junk && ($urandom_range(0, 9) == 0);
         bus_if.base_addr = AW'($urandom);
         bus_if.length = LW'($urandom_range(0, 20));
      end
      bus_if.start = 1'b0;
      check("done_within_bound", got, 1);
   endtask

   logic [AW-1:0] wrap_exp [4];
   logic          r_en [8], r_val [8], r_last [8], r_done [8], r_busy [8];
   logic [AW-1:0] r_addr [8];
   logic [DW-1:0] r_data [8];

   initial begin
      int b0, rd_cnt, bad;
      logic [AW-1:0] base;

      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      for (int i = 0; i < 4; i++) mem[16 + i] = 16'hC0DE + DW'(i);
      bus_if.start = 1'b0; bus_if.base_addr = '0; bus_if.length = '0; bus_if.m_ready = 1'b1;

      #1 rst = 1'b1;
      #1;
      check("rst_busy", bus_if.busy, 0);
      check("rst_done", bus_if.done, 0);
      check("rst_rd_en", bus_if.bram_rd_en, 0);
      check("rst_rd_addr", bus_if.bram_rd_addr, 0);
      check("rst_m_valid", bus_if.m_valid, 0);
      check("rst_m_data", bus_if.m_data, 0);
      check("rst_m_last", bus_if.m_last, 0);
      check("rst_state", bus_if.dbg_state, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Latency and throughput of a 4-word burst at full rate.
      start_burst(AW'(16), LW'(4));
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         r_en[c] = bus_if.bram_rd_en; r_addr[c] = bus_if.bram_rd_addr;
         r_val[c] = bus_if.m_valid; r_data[c] = bus_if.m_data; r_last[c] = bus_if.m_last;
         r_done[c] = bus_if.done; r_busy[c] = bus_if.busy;
      end
      for (int c = 1; c <= 4; c++) begin
         check("t1_rd_en", r_en[c], 1);
         check("t1_rd_addr", r_addr[c], 16 + c - 1);
      end
      check("t1_rd_en_c5", r_en[5], 0);
      check("t1_valid_c2", r_val[2], 0);
      for (int c = 3; c <= 6; c++) begin
         check("t1_valid", r_val[c], 1);
         check("t1_data", r_data[c], 16'hC0DE + c - 3);
         check("t1_last", r_last[c], c == 6);
      end
      check("t1_valid_c7", r_val[7], 0);
      check("t1_done_c6", r_done[6], 0);
      check("t1_done_c7", r_done[7], 1);
      check("t1_busy_c6", r_busy[6], 1);
      check("t1_busy_c7", r_busy[7], 0);

      // Address wrap.
      wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
      start_burst(10'h3FE, LW'(4));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("t2_wrap_addr", bus_if.bram_rd_addr, wrap_exp[c]);
      end
      wait_done(50, -1, 0);

      // Consumer stalled for cycles 3..9.
      bus_if.m_ready = 1'b0;
      base = AW'($urandom);
      b0 = beat_total;
      rd_cnt = 0;
      start_burst(base, LW'(8));
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (bus_if.bram_rd_en) rd_cnt++;
      end
      check("t3_reads_while_stalled", rd_cnt, 2);
      check("t3_valid_stalled", bus_if.m_valid, 1);
      check("t3_head_held", bus_if.m_data, mem[base]);
      @(posedge clk); #1 bus_if.m_ready = 1'b1;
      wait_done(100, -1, 0);
      check("t3_beats", beat_total - b0, 8);

      // Zero-length burst, then starts ignored while busy.
      start_burst(AW'($urandom), LW'(0));
      bad = 0;
      @(negedge clk);
      check("t4_done_len0", bus_if.done, 1);
      check("t4_busy_len0", bus_if.busy, 0);
      for (int c = 0; c < 3; c++) begin
         if (bus_if.bram_rd_en || bus_if.m_valid) bad++;
         @(negedge clk);
      end
      check("t4_no_activity_len0", bad, 0);
      b0 = beat_total;
      start_burst(AW'(100), LW'(4));
      @(posedge clk); #1;
      bus_if.start = 1'b1; bus_if.base_addr = AW'(200); bus_if.length = LW'(3);
      @(posedge clk); #1 bus_if.start = 1'b0;
      wait_done(50, -1, 0);
      check("t4_beats_ignored_start", beat_total - b0, 4);

      // Reset in the middle of a 16-word burst.
      b0 = beat_total;
      start_burst(AW'($urandom), LW'(16));
      for (int i = 0; i < 100 && beat_total < b0 + 5; i++) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_beats_before_rst", beat_total - b0, 5);
      check("t5_busy", bus_if.busy, 0);
      check("t5_done", bus_if.done, 0);
      check("t5_rd_en", bus_if.bram_rd_en, 0);
      check("t5_m_valid", bus_if.m_valid, 0);
      check("t5_m_data", bus_if.m_data, 0);
      check("t5_m_last", bus_if.m_last, 0);
      @(posedge clk); #1 rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.m_valid) bad++;
      end
      check("t5_quiet_after_rst", bad, 0);
      b0 = beat_total;
      start_burst(AW'(32), LW'(2));
      wait_done(50, -1, 0);
      check("t5_clean_beats", beat_total - b0, 2);

`ifdef BRAM_STREAM_PERF_EN
      bus_if.m_ready = 1'b0;
      start_burst(AW'($urandom), LW'(4));
      repeat (5) @(posedge clk);
      #1 bus_if.m_ready = 1'b1;
      wait_done(50, -1, 0);
      check("perf_stall_cnt", bus_if.stall_cnt, 3);
      start_burst(AW'($urandom), LW'(0));
      @(negedge clk);
      check("perf_cleared", bus_if.stall_cnt, 0);
`endif

      // Random bursts with random backpressure and junk starts while busy.
      for (int n = 0; n < 30; n++) begin
         logic [LW-1:0] len;
         len = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 40));
         bus_if.m_ready = $urandom_range(0, 1) == 1;
         start_burst(AW'($urandom), len);
         if (len == '0) begin
            repeat (2) @(posedge clk);
         end else begin
            wait_done(2000, int'($urandom_range(30, 100)), 1);
         end
      end
      bus_if.m_ready = 1'b1;
      repeat (4) @(posedge clk);
      check("final_model_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bram_read_streamer.md
Name: bram_read_streamer

Overview:
- Sequences burst reads from the single-port-read on-chip word buffer and presents the words as a valid/ready stream to the quantized linear-layer datapath.
- Accounts for the buffer's 1-cycle synchronous read latency and absorbs downstream backpressure with an internal 2-entry skid FIFO.
- Sustains 1 word/cycle when the consumer never stalls.
- Sits between the buffer's read port and the MAC/dequant front end. The write port is not touched.

Parameters:
- ADDR_WIDTH, 10, buffer address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, word width.
- LEN_WIDTH, 11, burst length width; maximum burst is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  burst request; sampled only when busy=0.
- base_addr  input  ADDR_WIDTH  first address of the burst; captured with start.
- length  input  LEN_WIDTH  number of words; captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the burst completes.
- bram_rd_en  output  1  read enable to the buffer.
- bram_rd_addr  output  ADDR_WIDTH  read address to the buffer.
- bram_rd_data  input  DATA_WIDTH  buffer read data, valid the cycle after bram_rd_en.
- m_valid  output  1  stream word valid.
- m_ready  input  1  consumer ready.
- m_data  output  DATA_WIDTH  stream word.
- m_last  output  1  high with the final word of the burst.

Behaviour:
- Reset (async assert, applied immediately): busy=0, done=0, bram_rd_en=0, bram_rd_addr=0, m_valid=0, m_data=0, m_last=0. FIFO, in-flight flag, counters and FSM are cleared. Reset mid-burst aborts the burst: no done pulse, and pending words are discarded.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: start=1 with length>0 → capture base_addr/length, issue_cnt=length, beat_cnt=length, go to RUN.
  - IDLE: start=1 with length=0 → no reads, no beats, done pulse next cycle, remain IDLE.
  - RUN: issue_cnt reaches 0 → FLUSH.
  - FLUSH: final beat handshake (beat_cnt 1→0) → IDLE, with done=1 for 1 cycle and busy=0 in that same cycle.
  - start while busy=1 is ignored.
- Issue rule, combinational: bram_rd_en = (state==RUN) & (issue_cnt>0) & ((fifo_count + inflight - pop) < 2), where pop = m_valid & m_ready.
  - Each issue increments the address, wrapping 2^ADDR_WIDTH-1 → 0, and decrements issue_cnt.
  - bram_rd_addr holds the current address; it is a don't-care when rd_en=0.
- inflight is a registered copy of bram_rd_en. When inflight=1, bram_rd_data is pushed into the FIFO at the end of that cycle.
  - The FIFO never overflows by construction; overflow is an assertion failure.
- Stream: m_valid = FIFO non-empty; m_data is the FIFO head.
  - m_last = head is the final word (beat_cnt==1).
  - Word order equals address order.
  - m_data/m_last are held stable while m_valid=1 and m_ready=0.
- Latency: start is sampled at the end of cycle 0.
  - bram_rd_en goes high in cycle 1.
  - The data word enters the FIFO at the end of cycle 2.
  - m_valid goes high in cycle 3.
  - With m_ready held at 1, words appear on consecutive cycles.
- Simultaneous push and pop on the FIFO are allowed, and the count is unchanged.

Optional Feature:
- Macro: BRAM_STREAM_PERF_EN.
- Enabled: adds output stall_cnt, 16 bits. It counts cycles with m_valid=1 & m_ready=0 during busy, saturates at 0xFFFF, is cleared by an accepted start, holds after done, and resets to 0.
- Disabled: the port and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- base 0x010, length 4, m_ready=1 → rd_addr 0x010..0x013 in cycles 1–4; m_data = mem[0x010..0x013] in cycles 3–6; m_last only in cycle 6; done=1 in cycle 7; busy=0 from cycle 7.
- base 0x3FE, length 4 → rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; data order matches.
- length 8, m_ready=0 for cycles 3–9 → at most 2 reads issued while stalled; no word lost or duplicated; all 8 words delivered in order after m_ready rises.
- length 0 → done pulse next cycle; bram_rd_en and m_valid never assert. Second start pulsed while busy during a length-4 burst → ignored, exactly 4 beats.
- rst asserted mid-burst of length 16 after 5 beats → outputs 0 immediately, no done. A new start with base 0x020, length 2 afterwards → clean 2-beat burst.
- PERF_EN: length 4 with m_ready low for 3 cycles while m_valid=1 → stall_cnt=3; next start → stall_cnt=0.
